// File: rtl/wb_master_seq.sv
// Wishbone classic single-transfer initiator: one command in, one bus cycle,
// one response out, with a stb-timeout abort and a saturating error counter.
module wb_master_seq #(
  parameter int unsigned TIMEOUT  = 16,
  parameter int unsigned ERRCNT_W = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_we,
  input  logic [31:0]         cmd_adr,
  input  logic [31:0]         cmd_dat,
  input  logic [3:0]          cmd_sel,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [31:0]         rsp_dat,
  output logic                rsp_err,
  output logic                wbm_cyc_o,
  output logic                wbm_stb_o,
  output logic                wbm_we_o,
  output logic [3:0]          wbm_sel_o,
  output logic [31:0]         wbm_adr_o,
  output logic [31:0]         wbm_dat_o,
  input  logic                wbm_ack_i,
  input  logic [31:0]         wbm_dat_i,
  output logic [ERRCNT_W-1:0] err_count
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] tcnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      tcnt      <= '0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_dat   <= '0;
      rsp_err   <= 1'b0;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= '0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      err_count <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            wbm_we_o  <= cmd_we;
            wbm_adr_o <= cmd_adr;
            wbm_dat_o <= cmd_dat;
            wbm_sel_o <= cmd_sel;
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            tcnt      <= '0;
            cmd_ready <= 1'b0;
            state     <= BUS;
          end
        end

        BUS: begin
          // Ack is checked first so an ack on the last permitted cycle succeeds.
          if (wbm_ack_i || tcnt == TLAST) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= '0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            rsp_valid <= 1'b1;
            state     <= RESP;
            if (wbm_ack_i) begin
              rsp_err <= 1'b0;
              rsp_dat <= wbm_we_o ? '0 : wbm_dat_i;
            end else begin
              rsp_err <= 1'b1;
              rsp_dat <= '0;
              if (err_count != '1)
                err_count <= err_count + 1'b1;
            end
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end

        RESP: begin
          if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_dat   <= '0;
            rsp_err   <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_master_seq.sv
// Directed self-checking bench for wb_master_seq with a registered-ack slave
// whose ack delay (in stb cycles) is programmable; 0 means never ack.
module tb_wb_master_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_adr, cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_dat;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic [7:0]  err_count;

  logic        slv_ack   = 1'b0;
  logic        stray_ack = 1'b0;
  logic [31:0] slv_dat   = 32'hA5A5_A5A5;
  logic [31:0] mem [16];
  int          ack_delay = 2;
  int          stb_cnt   = 0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign wbm_ack_i = slv_ack | stray_ack;
  assign wbm_dat_i = slv_dat;

  wb_master_seq #(.TIMEOUT(16), .ERRCNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i), .err_count(err_count)
  );

  initial for (int i = 0; i < 16; i++) mem[i] = '0;

  // Slave: ack rises for stb cycle number ack_delay (1-based), never when 0.
  always @(posedge clk) begin
    if (wbm_cyc_o && wbm_stb_o) stb_cnt <= stb_cnt + 1;
    else                        stb_cnt <= 0;
    slv_ack <= 1'b0;
    if (wbm_cyc_o && wbm_stb_o && !slv_ack && ack_delay >= 2 && stb_cnt == ack_delay - 2) begin
      slv_ack <= 1'b1;
      if (wbm_we_o) begin
        for (int b = 0; b < 4; b++)
          if (wbm_sel_o[b]) mem[wbm_adr_o[5:2]][8*b +: 8] <= wbm_dat_o[8*b +: 8];
      end else begin
        slv_dat <= mem[wbm_adr_o[5:2]];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called just after a negedge; returns just after the negedge following the handshake edge.
  task automatic send_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, output bit ok);
    int n = 0;
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = cmd_ready;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, output int stb_n, output int lat, output bit stable);
    stb_n = 0; lat = 1; stable = 1'b1;
    while (!rsp_valid && lat < 64) begin
      if (wbm_stb_o) begin
        stb_n++;
        if (!wbm_cyc_o || wbm_we_o !== we || wbm_adr_o !== adr ||
            wbm_dat_o !== dat || wbm_sel_o !== sel) stable = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic txn(input string tag, input logic we, input logic [31:0] adr,
                     input logic [31:0] dat, input logic [3:0] sel,
                     input logic [31:0] exp_dat, input logic exp_err, input int exp_stb);
    bit ok, stable;
    int stb_n, lat;
    send_cmd(we, adr, dat, sel, ok);
    check({tag, "_handshake"}, 32'(ok), 1);
    wait_rsp(we, adr, dat, sel, stb_n, lat, stable);
    check({tag, "_stb_cycles"}, stb_n, exp_stb);
    check({tag, "_rsp_latency"}, lat, exp_stb + 1);
    check({tag, "_bus_stable"}, 32'(stable), 1);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 1);
    check({tag, "_rsp_dat"}, rsp_dat, exp_dat);
    check({tag, "_rsp_err"}, 32'(rsp_err), 32'(exp_err));
    check({tag, "_bus_cleared"}, {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o} , 0);
    check({tag, "_adr_cleared"}, wbm_adr_o, 0);
    take_rsp();
    check({tag, "_rsp_done"}, {rsp_valid, rsp_err}, 0);
    check({tag, "_rsp_dat_clr"}, rsp_dat, 0);
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 1);
  endtask

  initial begin
    bit ok, stable;
    int stb_n, lat;

    reset_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0;
    cmd_sel = '0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 1);
    check("rst_rsp", {rsp_valid, rsp_err}, 0);
    check("rst_bus", {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o}, 0);
    check("rst_adr_dat", wbm_adr_o | wbm_dat_o | rsp_dat, 0);
    check("rst_err_count", err_count, 0);
    reset_n = 1'b1;
    @(negedge clk);

    ack_delay = 2;
    txn("wr", 1'b1, 32'h3000_0004, 32'h0000_FF00, 4'hF, 32'h0, 1'b0, 2);
    txn("rd", 1'b0, 32'h3000_0004, 32'h0,         4'hF, 32'h0000_FF00, 1'b0, 2);

    // Ack arriving on the 16th stb cycle must win over the timeout.
    txn("wr_db", 1'b1, 32'h3000_0008, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, 2);
    ack_delay = 16;
    txn("ack_last", 1'b0, 32'h3000_0008, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b0, 16);
    check("ack_last_err_count", err_count, 0);

    // Stray ack while idle.
    ack_delay = 2;
    stray_ack = 1'b1;
    @(negedge clk);
    stray_ack = 1'b0;
    check("stray_idle_bus", {wbm_cyc_o, wbm_stb_o}, 0);
    check("stray_idle_rsp", {rsp_valid, rsp_dat}, 0);
    check("stray_idle_ready", 32'(cmd_ready), 1);
    @(negedge clk);
    check("stray_idle_rsp2", 32'(rsp_valid), 0);

    // Response backpressure with a pending command and a stray ack in RESP.
    send_cmd(1'b0, 32'h3000_0004, 32'h0, 4'hF, ok);
    check("bp_handshake", 32'(ok), 1);
    wait_rsp(1'b0, 32'h3000_0004, 32'h0, 4'hF, stb_n, lat, stable);
    check("bp_rsp_valid", 32'(rsp_valid), 1);
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h3000_0010;
    cmd_dat = 32'h1234_5678; cmd_sel = 4'h3;
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid !== 1'b1 || rsp_dat !== 32'h0000_FF00 || rsp_err !== 1'b0 ||
          cmd_ready !== 1'b0 || wbm_stb_o !== 1'b0) stable = 1'b0;
      stray_ack = (i == 2);
      @(negedge clk);
    end
    stray_ack = 1'b0;
    check("bp_hold_stable", 32'(stable), 1);
    check("bp_rsp_dat", rsp_dat, 32'h0000_FF00);
    check("bp_cmd_ready_low", 32'(cmd_ready), 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("bp_cmd_ready", 32'(cmd_ready), 1);
    check("bp_rsp_cleared", 32'(rsp_valid), 0);
    check("bp_no_early_stb", 32'(wbm_stb_o), 0);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("bp_accept_stb", 32'(wbm_stb_o), 1);
    check("bp_accept_adr", wbm_adr_o, 32'h3000_0010);
    wait_rsp(1'b1, 32'h3000_0010, 32'h1234_5678, 4'h3, stb_n, lat, stable);
    check("bp_wr_stable", 32'(stable), 1);
    check("bp_wr_rsp", {rsp_valid, rsp_err}, 2'b10);
    take_rsp();
    txn("rd_sel", 1'b0, 32'h3000_0010, 32'h0, 4'hF, 32'h0000_5678, 1'b0, 2);

    // Timeouts: 16 stb cycles each, counter saturates at 0xFF.
    ack_delay = 0;
    for (int k = 1; k <= 300; k++) begin
      txn("timeout", 1'b0, 32'h3000_0FF0, 32'h0, 4'hF, 32'h0, 1'b1, 16);
      check("timeout_err_count", err_count, (k > 255) ? 255 : k);
    end

    // Reset during the 3rd stb cycle.
    send_cmd(1'b0, 32'h3000_0FF0, 32'h0, 4'hF, ok);
    check("mid_handshake", 32'(ok), 1);
    repeat (2) @(negedge clk);
    check("mid_stb_before", 32'(wbm_stb_o), 1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("mid_bus_dropped", {wbm_cyc_o, wbm_stb_o}, 0);
    check("mid_rsp", 32'(rsp_valid), 0);
    check("mid_cmd_ready", 32'(cmd_ready), 1);
    check("mid_err_count", err_count, 0);
    stray_ack = 1'b1;
    @(negedge clk);
    stray_ack = 1'b0;
    stable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid !== 1'b0 || wbm_cyc_o !== 1'b0 || cmd_ready !== 1'b1) stable = 1'b0;
      @(negedge clk);
    end
    check("mid_no_response", 32'(stable), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
